// File: rtl/mips_cpu_state_machine.sv
// rtl/mips_cpu_state_machine.sv - multicycle MIPS sequencing FSM with stall detection and retire counter
// Sequences HALT/FETCH/DECODE/EXEC1/EXEC2 for the controller; a boot flag gives exactly one restart per reset.

module mips_cpu_state_machine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  fncode,
  input  logic [4:0]  regimm,
  input  logic [31:0] pc,
  input  logic        waitrequest,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        muldiv_busy,
  output logic [2:0]  state,
  output logic        active,
  output logic        stall,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC1  = 3'd3,
    S_EXEC2  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        boot_q, boot_d;
  logic [31:0] count_q;
  logic        retire;
  logic        mem_wait, md_wait, needs_exec2;

  assign mem_wait    = (memread | memwrite) & waitrequest;
  assign md_wait     = (opcode == 6'h00) && (fncode inside {[6'h18:6'h1B]}) && muldiv_busy;
  // Loads and the linking REGIMM branches need a second execute cycle.
  assign needs_exec2 = (opcode inside {[6'h20:6'h26]}) ||
                       ((opcode == 6'h01) && (regimm inside {5'h10, 5'h11}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HALT;
      boot_q  <= 1'b1;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      if (retire) count_q <= count_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    boot_d  = boot_q;
    retire  = 1'b0;
    stall   = 1'b0;
    active  = 1'b0;
    case (state_q)
      S_HALT: begin
        if (boot_q) begin
          state_d = S_FETCH;
          boot_d  = 1'b0;
        end
      end
      S_FETCH: begin
        active = 1'b1;
        // A fetch from address zero means the program has returned; its read is discarded.
        if (pc == 32'h0)      state_d = S_HALT;
        else if (waitrequest) stall   = 1'b1;
        else                  state_d = S_DECODE;
      end
      S_DECODE: begin
        active  = 1'b1;
        state_d = S_EXEC1;
      end
      S_EXEC1: begin
        active = 1'b1;
        if (mem_wait || md_wait) stall = 1'b1;
        else if (needs_exec2)    state_d = S_EXEC2;
        else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC2: begin
        active = 1'b1;
        if (mem_wait) stall = 1'b1;
        else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule
